vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Source end of the vga_if pixel stream.
- Generates hcount, vcount, hsync, vsync, hblnk and vblnk for 800x600@60 (40 MHz pixel clock).
- Drives rgb to a constant background so that downstream draw stages (background, platforms, character, crown) can overlay sprites.
- Also emits a one-cycle frame_start strobe that game-physics blocks use as their update tick.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- BG_RGB, 12'h000, rgb driven on every pixel

Ports:
- clk, in, 1, pixel clock, 40 MHz
- rst, in, 1, synchronous active-high reset
- vga_out, vga_if.out, modport, hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_start, out, 1, single-cycle pulse on the cycle the stream presents hcount=0, vcount=0

Behaviour:
- Totals:
  - H_TOTAL = sum of the H_* parameters = 1056.
  - V_TOTAL = sum of the V_* parameters = 628.
  - Both counters are 11 bit.
- Counting:
  - hcount increments every clk and wraps from H_TOTAL-1 to 0.
  - vcount increments only on the cycle hcount wraps, and wraps from V_TOTAL-1 to 0.
  - The wrap of hcount at (1055, 627) also wraps vcount, returning the stream to (0, 0).
- Decoding (all outputs registered, computed from the next counter values, so every field of vga_out describes the same pixel in the same cycle):
  - hblnk = hcount >= H_VISIBLE
  - hsync = H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 840..967
  - vblnk = vcount >= V_VISIBLE
  - vsync = V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. 601..604
  - Sync polarity is active-high on the interface; the top level handles pad inversion.
  - rgb = BG_RGB, with no blanking gating here (downstream handles blanking).
- frame_start is 1 exactly on the cycle vga_out shows (0, 0), otherwise 0.
- Latency: none beyond the output register. Every output field corresponds to the same counter state.
- Reset:
  - While rst is high, all outputs are 0 and frame_start is 0.
  - On the first clk after rst falls, the stream shows (0, 0) with frame_start=1.
  - rst asserted mid-frame aborts the frame; the next frame restarts cleanly at (0, 0).
- Elaboration: a compile-time assertion requires H_TOTAL <= 2048 and V_TOTAL <= 2048.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - In the visible area, rgb = 8 vertical colour bars of width H_VISIBLE/8: 12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - A 1-pixel white 12'hFFF border is drawn at hcount 0/799 and vcount 0/599, overriding the bars.
  - rgb = 0 during blanking.
- When undefined: rgb = BG_RGB at all times.
- Timing outputs are identical in both builds.

Decomposition:
- vga_pkg holds:
  - the 800x600 timing constants, which supply the parameter defaults
  - the derived H_TOTAL, V_TOTAL and sync start/end localparams
  - the test-pattern bar colour array
- One sub-module, vga_axis_counter: parameterised total, with enable and wrap outputs. It is instantiated twice; the horizontal instance's wrap output drives the vertical instance's enable.

Test Plan:
- Release rst after 5 cycles -> first output (0, 0), frame_start=1, hblnk=0, vblnk=0, hsync=0, vsync=0.
- Run 1 line -> hblnk rises at hcount 800; hsync is high for hcount 840..967 (128 cycles); hcount wraps 1055->0 with vcount 0->1.
- Run 1 full frame -> frame_start period is exactly 1056*628 = 663168 cycles; vsync high for vcount 601..604; vblnk high for 600..627.
- At (1055, 627) -> next cycle shows (0, 0), frame_start=1, hblnk=0, vblnk=0.
- Assert rst at (400, 300) for 2 cycles -> outputs 0 during rst; after release, (0, 0) with frame_start=1, and a full 663168-cycle frame follows.
- VGA_TEST_PATTERN_EN build: at (50, 10) rgb=12'hFFF, (150, 10) rgb=12'hFF0, (0, 300) rgb=12'hFFF (border), (900, 300) rgb=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants, derived totals and test-pattern colours.
// The bar colours are only used when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE = 800;
  localparam int unsigned VGA_H_FRONT   = 40;
  localparam int unsigned VGA_H_SYNC    = 128;
  localparam int unsigned VGA_H_BACK    = 88;
  localparam int unsigned VGA_V_VISIBLE = 600;
  localparam int unsigned VGA_V_FRONT   = 1;
  localparam int unsigned VGA_V_SYNC    = 4;
  localparam int unsigned VGA_V_BACK    = 23;
  localparam logic [11:0] VGA_BG_RGB    = 12'h000;

  localparam int unsigned VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam int unsigned VGA_CNT_W = 11;

  // Bar 0 is the leftmost bar on screen.
  localparam logic [0:7][11:0] VGA_BAR_RGB = {
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  typedef struct packed {
    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
    logic [11:0]          rgb;
  } vga_px_t;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed between VGA draw stages; syncs are active-high.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one screen axis; exposes its next value and
// a wrap strobe that is high when an enabled step returns the count to 0.
module vga_axis_counter #(
  parameter int unsigned TOTAL = 1056,
  parameter int unsigned W     = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_last_s;

  always_comb begin
    at_last_s = (count_q == LAST);
    wrap_o    = en_i & at_last_s;
    if (!en_i) begin
      count_d = count_q;
    end else if (at_last_s) begin
      count_d = '0;
    end else begin
      count_d = count_q + W'(1);
    end
  end

  // Reset parks on the last position so the first enabled step lands on 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign next_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// 800x600@60 VGA timing source with registered decode and a frame_start tick.
// Define VGA_TEST_PATTERN_EN to replace the flat background with colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter logic [11:0] BG_RGB    = VGA_BG_RGB
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out,
  output logic frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [VGA_CNT_W-1:0] H_VIS_C   = VGA_CNT_W'(H_VISIBLE);
  localparam logic [VGA_CNT_W-1:0] H_SS_C    = VGA_CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [VGA_CNT_W-1:0] H_SE_C    = VGA_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VGA_CNT_W-1:0] V_VIS_C   = VGA_CNT_W'(V_VISIBLE);
  localparam logic [VGA_CNT_W-1:0] V_SS_C    = VGA_CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [VGA_CNT_W-1:0] V_SE_C    = VGA_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  logic [VGA_CNT_W-1:0] h_next_s;
  logic [VGA_CNT_W-1:0] v_next_s;
  logic                 h_wrap_s;
  logic                 v_wrap_s;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(VGA_CNT_W)) u_hcnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (1'b1),
    .next_o (h_next_s),
    .wrap_o (h_wrap_s)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(VGA_CNT_W)) u_vcnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (h_wrap_s),
    .next_o (v_next_s),
    .wrap_o (v_wrap_s)
  );

  vga_px_t px_d;
  vga_px_t px_q;
  logic    fs_d;
  logic    fs_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [VGA_CNT_W-1:0] BAR_W_C = VGA_CNT_W'(H_VISIBLE / 8);
  logic [VGA_CNT_W-1:0] bar_idx_s;
  logic [2:0]           bar_sel_s;
  logic                 visible_s;
  logic                 border_s;
`endif

  // Decode the upcoming position so every registered field matches it.
  always_comb begin
    px_d        = '0;
    px_d.hcount = h_next_s;
    px_d.vcount = v_next_s;
    px_d.hblnk  = (h_next_s >= H_VIS_C);
    px_d.hsync  = (h_next_s >= H_SS_C) && (h_next_s < H_SE_C);
    px_d.vblnk  = (v_next_s >= V_VIS_C);
    px_d.vsync  = (v_next_s >= V_SS_C) && (v_next_s < V_SE_C);
    fs_d        = h_wrap_s & v_wrap_s;
`ifdef VGA_TEST_PATTERN_EN
    visible_s = (h_next_s < H_VIS_C) && (v_next_s < V_VIS_C);
    border_s  = (h_next_s == '0) || (h_next_s == H_VIS_C - VGA_CNT_W'(1)) ||
                (v_next_s == '0) || (v_next_s == V_VIS_C - VGA_CNT_W'(1));
    bar_idx_s = h_next_s / BAR_W_C;
    bar_sel_s = (bar_idx_s > VGA_CNT_W'(7)) ? 3'd7 : bar_idx_s[2:0];
    if (!visible_s) begin
      px_d.rgb = 12'h000;
    end else if (border_s) begin
      px_d.rgb = 12'hFFF;
    end else begin
      px_d.rgb = VGA_BAR_RGB[bar_sel_s];
    end
`else
    px_d.rgb = BG_RGB;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q <= '0;
      fs_q <= 1'b0;
    end else begin
      px_q <= px_d;
      fs_q <= fs_d;
    end
  end

  assign vga_out.hcount = px_q.hcount;
  assign vga_out.vcount = px_q.vcount;
  assign vga_out.hsync  = px_q.hsync;
  assign vga_out.vsync  = px_q.vsync;
  assign vga_out.hblnk  = px_q.hblnk;
  assign vga_out.vblnk  = px_q.vblnk;
  assign vga_out.rgb    = px_q.rgb;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three timing configurations share one reset; expected
// pixels come from position arithmetic (cycle index modulo line/frame size).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  typedef struct {
    int          hv, hf, hs, hb;
    int          vv, vf, vs, vb;
    logic [11:0] bg;
  } cfg_t;

  logic clk = 1'b0;
  logic rst;
  logic fs_s, fs_d, fs_v;

  always #5 clk = ~clk;

  vga_if vif_s ();
  vga_if vif_d ();
  vga_if vif_v ();

  // Small frame, non-zero background.
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .BG_RGB(12'h5A3)
  ) u_dut_s (.clk(clk), .rst(rst), .vga_out(vif_s), .frame_start(fs_s));

  // Full 800x600 defaults.
  vga_timing_gen u_dut_d (.clk(clk), .rst(rst), .vga_out(vif_d), .frame_start(fs_d));

  // Short lines with the default vertical timing, so a full 628-line frame fits.
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4)
  ) u_dut_v (.clk(clk), .rst(rst), .vga_out(vif_v), .frame_start(fs_v));

  cfg_t cfg [3];
  int   period [3];
  obs_t expq [3][$];
  int   pos;
  int   n_checks;
  int   n_fail;
  int   cyc;

  function automatic obs_t model(input bit r, input int p, input cfg_t c);
    obs_t o;
    int ht, vt, h, v, bar;
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    o = '0;
    if (!r) begin
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      h  = p % ht;
      v  = (p / ht) % vt;
      o.h  = 11'(h);
      o.v  = 11'(v);
      o.hb = (h >= c.hv);
      o.hs = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs);
      o.vb = (v >= c.vv);
      o.vs = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs);
      o.fs = (h == 0) && (v == 0);
`ifdef VGA_TEST_PATTERN_EN
      bar = h / (c.hv / 8);
      if (bar > 7) bar = 7;
      if (h >= c.hv || v >= c.vv) o.rgb = 12'h000;
      else if (h == 0 || h == c.hv - 1 || v == 0 || v == c.vv - 1) o.rgb = 12'hFFF;
      else o.rgb = bars[bar];
`else
      bar = 0;
      o.rgb = c.bg + 12'(bar);
`endif
    end
    return o;
  endfunction

  task automatic step(input bit r);
    rst = r;
    if (r) pos = -1;
    else   pos = pos + 1;
    for (int i = 0; i < 3; i++) expq[i].push_back(model(r, pos, cfg[i]));
    @(posedge clk);
    #3;
  endtask

  // Monitor: pop one expectation per DUT per cycle and compare.
  initial begin
    obs_t got [3];
    obs_t e;
    int   cnt [3];
    bit   have [3];
    for (int i = 0; i < 3; i++) begin
      cnt[i]  = 0;
      have[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      got[0] = {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, fs_s};
      got[1] = {vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync, vif_d.hblnk, vif_d.vblnk, vif_d.rgb, fs_d};
      got[2] = {vif_v.hcount, vif_v.vcount, vif_v.hsync, vif_v.vsync, vif_v.hblnk, vif_v.vblnk, vif_v.rgb, fs_v};
      for (int i = 0; i < 3; i++) begin
        n_checks = n_checks + 1;
        if (expq[i].size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL scoreboard_empty dut=%0d cyc=%0d", i, cyc);
        end else begin
          e = expq[i].pop_front();
          if (got[i] !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL pixel dut=%0d cyc=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b exp h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b",
                     i, cyc, got[i].h, got[i].v, got[i].hs, got[i].vs, got[i].hb, got[i].vb, got[i].rgb, got[i].fs,
                     e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb, e.fs);
          end
        end
        // Frame period between consecutive frame_start pulses with no reset between.
        if (period[i] > 0) begin
          if (rst) begin
            have[i] = 1'b0;
          end else if (got[i].fs) begin
            if (have[i]) begin
              n_checks = n_checks + 1;
              if (cnt[i] != period[i]) begin
                n_fail = n_fail + 1;
                $display("FAIL frame_period dut=%0d cyc=%0d got=%0d exp=%0d", i, cyc, cnt[i], period[i]);
              end
            end
            have[i] = 1'b1;
            cnt[i]  = 1;
          end else begin
            cnt[i] = cnt[i] + 1;
          end
        end
      end
    end
  end

  initial begin
    int len;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    pos      = -1;
    cfg[0] = '{hv:16,  hf:4,  hs:8,   hb:4,  vv:12,  vf:1, vs:2, vb:3,  bg:12'h5A3};
    cfg[1] = '{hv:800, hf:40, hs:128, hb:88, vv:600, vf:1, vs:4, vb:23, bg:12'h000};
    cfg[2] = '{hv:16,  hf:4,  hs:8,   hb:4,  vv:600, vf:1, vs:4, vb:23, bg:12'h000};
    period[0] = 32 * 18;
    period[1] = 0;
    period[2] = 32 * 628;

    for (int k = 0; k < 5; k++) step(1'b1);
    for (int k = 0; k < 20500; k++) step(1'b0);
    // Mid-frame abort, then a clean restart and at least one full small frame.
    for (int k = 0; k < 2; k++) step(1'b1);
    for (int k = 0; k < 1500; k++) step(1'b0);
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
